// File: rtl/pkt_tx_ctrl.sv
// pkt_tx_ctrl -- egress side of a packet FIFO.
//
// Fetches committed packets from a FIFO that has a one-cycle read latency.
// Fetched words go into a 2-entry skid buffer and are emitted downstream
// at up to one word per cycle under out_rdy back-pressure.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset (also resets the FIFO)
//   pkt_done    1-cycle pulse: one complete packet committed to the FIFO
//   fiforead    FIFO read request; data returns on the next cycle
//   valid_data  in_fifo holds a valid FIFO word
//   in_fifo     FIFO word: ctrl in the top CTRL_WIDTH bits, data below it
//   out_data    egress payload (head of the skid buffer, registered)
//   out_ctrl    egress control (head of the skid buffer, registered)
//   out_wr      egress write strobe
//   out_rdy     downstream accepts a word this cycle
//   pkt_avail   committed packets whose EOP word has not been fetched yet
//   tx_busy     egress state not IDLE, or the skid buffer holds words
//
// Optional feature (macro TX_PKT_STATS_EN):
//   tx_pkt_count   transmitted EOP words, wraps modulo 2^32
//   tx_word_count  transmitted words (out_wr pulses), wraps modulo 2^32
//
// Control decode: 0xFF = header, 0x00 = payload, anything else = EOP.
module pkt_tx_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pkt_done,
  output logic                           fiforead,
  input  logic                           valid_data,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_fifo,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  output logic [CNT_WIDTH-1:0]           pkt_avail,
  output logic                           tx_busy
`ifdef TX_PKT_STATS_EN
  ,
  output logic [31:0]                    tx_pkt_count,
  output logic [31:0]                    tx_word_count
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
  localparam logic [CTRL_WIDTH-1:0] CTRL_ONES = {CTRL_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // Control-word decode helpers shared by the ingress and egress sides.
  function automatic logic is_hdr_ctrl(input logic [CTRL_WIDTH-1:0] c);
    return (c == CTRL_ONES);
  endfunction

  function automatic logic is_data_ctrl(input logic [CTRL_WIDTH-1:0] c);
    return (c == CTRL_ZERO);
  endfunction

  function automatic logic is_eop_ctrl(input logic [CTRL_WIDTH-1:0] c);
    return (c != CTRL_ZERO) && (c != CTRL_ONES);
  endfunction

  // Registers
  logic [CNT_WIDTH-1:0]  avail_r;
  logic                  rd_inflight_r;
  logic                  prev_eop_r;
  logic [1:0]            occ_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [CTRL_WIDTH-1:0] out_ctrl_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic [CTRL_WIDTH-1:0] skid_ctrl_r;
  logic [1:0]            state_r;

  // Combinational signals
  logic [DATA_WIDTH-1:0] in_data_s;
  logic [CTRL_WIDTH-1:0] in_ctrl_s;
  logic                  accept_s;
  logic                  in_eop_s;
  logic                  pop_s;
  logic [2:0]            level_s;
  logic                  fiforead_s;
  logic [CNT_WIDTH-1:0]  avail_nxt_s;
  logic [1:0]            occ_nxt_s;
  logic [DATA_WIDTH-1:0] head_data_nxt_s;
  logic [CTRL_WIDTH-1:0] head_ctrl_nxt_s;
  logic [DATA_WIDTH-1:0] skid_data_nxt_s;
  logic [CTRL_WIDTH-1:0] skid_ctrl_nxt_s;
  logic [1:0]            state_nxt_s;

  assign in_data_s = in_fifo[DATA_WIDTH-1:0];
  assign in_ctrl_s = in_fifo[DATA_WIDTH +: CTRL_WIDTH];

  // A returned word is only taken when this block asked for it last cycle;
  // this discards data answering a read that was issued before a reset.
  assign accept_s = valid_data & rd_inflight_r;

  // An EOP-coded word directly after another EOP is not a new boundary.
  assign in_eop_s = accept_s & is_eop_ctrl(in_ctrl_s) & ~prev_eop_r;

  assign pop_s = out_rdy & (occ_r != 2'd0);

  // Words that will be held after this cycle's pop, plus the word already
  // on its way from the FIFO. Counting the pop lets a read issue every
  // cycle while the downstream keeps up.
  assign level_s    = {1'b0, occ_r} - {2'b00, pop_s} + {2'b00, rd_inflight_r};
  assign fiforead_s = (avail_r != CNT_ZERO) & (level_s < 3'd2);

  // Pending-packet counter next value, saturating at both ends.
  always_comb begin
    avail_nxt_s = avail_r;
    if (pkt_done && !in_eop_s) begin
      if (avail_r != CNT_MAX) begin
        avail_nxt_s = avail_r + CNT_ONE;
      end else begin
        avail_nxt_s = avail_r;
      end
    end else if (in_eop_s && !pkt_done) begin
      if (avail_r != CNT_ZERO) begin
        avail_nxt_s = avail_r - CNT_ONE;
      end else begin
        avail_nxt_s = avail_r;
      end
    end else begin
      avail_nxt_s = avail_r;
    end
  end

  // Skid buffer next state: the head register drives the outputs directly,
  // the second entry catches the word in flight when the downstream stalls.
  always_comb begin
    head_data_nxt_s = out_data_r;
    head_ctrl_nxt_s = out_ctrl_r;
    skid_data_nxt_s = skid_data_r;
    skid_ctrl_nxt_s = skid_ctrl_r;
    occ_nxt_s       = occ_r;
    case (occ_r)
      2'd0: begin
        if (accept_s) begin
          head_data_nxt_s = in_data_s;
          head_ctrl_nxt_s = in_ctrl_s;
          occ_nxt_s       = 2'd1;
        end else begin
          occ_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (accept_s && pop_s) begin
          head_data_nxt_s = in_data_s;
          head_ctrl_nxt_s = in_ctrl_s;
          occ_nxt_s       = 2'd1;
        end else if (accept_s) begin
          skid_data_nxt_s = in_data_s;
          skid_ctrl_nxt_s = in_ctrl_s;
          occ_nxt_s       = 2'd2;
        end else if (pop_s) begin
          occ_nxt_s = 2'd0;
        end else begin
          occ_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_data_nxt_s = skid_data_r;
          head_ctrl_nxt_s = skid_ctrl_r;
          if (accept_s) begin
            skid_data_nxt_s = in_data_s;
            skid_ctrl_nxt_s = in_ctrl_s;
            occ_nxt_s       = 2'd2;
          end else begin
            occ_nxt_s = 2'd1;
          end
        end else begin
          // The read throttle keeps a word from arriving while full.
          occ_nxt_s = 2'd2;
        end
      end
      default: begin
        occ_nxt_s = 2'd0;
      end
    endcase
  end

  // Egress state machine, advanced by each word that leaves the buffer.
  always_comb begin
    state_nxt_s = state_r;
    if (pop_s) begin
      case (state_r)
        ST_IDLE: begin
          if (is_hdr_ctrl(out_ctrl_r)) begin
            state_nxt_s = ST_HDR;
          end else if (is_data_ctrl(out_ctrl_r)) begin
            state_nxt_s = ST_PAYLOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (is_data_ctrl(out_ctrl_r)) begin
            state_nxt_s = ST_PAYLOAD;
          end else begin
            state_nxt_s = ST_HDR;
          end
        end
        ST_PAYLOAD: begin
          if (!is_data_ctrl(out_ctrl_r)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Control registers: pending count, read tracking, occupancy, FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avail_r       <= CNT_ZERO;
      rd_inflight_r <= 1'b0;
      prev_eop_r    <= 1'b0;
      occ_r         <= 2'd0;
      state_r       <= ST_IDLE;
    end else begin
      avail_r       <= avail_nxt_s;
      rd_inflight_r <= fiforead_s;
      if (accept_s) begin
        prev_eop_r <= in_eop_s;
      end else begin
        prev_eop_r <= prev_eop_r;
      end
      occ_r   <= occ_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Data registers of the skid buffer (head entry is the output register).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r  <= DATA_ZERO;
      out_ctrl_r  <= CTRL_ZERO;
      skid_data_r <= DATA_ZERO;
      skid_ctrl_r <= CTRL_ZERO;
    end else begin
      out_data_r  <= head_data_nxt_s;
      out_ctrl_r  <= head_ctrl_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_ctrl_r <= skid_ctrl_nxt_s;
    end
  end

  assign fiforead  = fiforead_s;
  assign out_data  = out_data_r;
  assign out_ctrl  = out_ctrl_r;
  assign out_wr    = pop_s;
  assign pkt_avail = avail_r;
  assign tx_busy   = (state_r != ST_IDLE) | (occ_r != 2'd0);

`ifdef TX_PKT_STATS_EN
  logic [31:0] tx_pkt_count_r;
  logic [31:0] tx_word_count_r;
  logic        tx_eop_s;

  assign tx_eop_s = pop_s & (state_r == ST_PAYLOAD) & is_eop_ctrl(out_ctrl_r);

  // Transmit statistics, free-running and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_pkt_count_r  <= 32'd0;
      tx_word_count_r <= 32'd0;
    end else begin
      if (tx_eop_s) begin
        tx_pkt_count_r <= tx_pkt_count_r + 32'd1;
      end else begin
        tx_pkt_count_r <= tx_pkt_count_r;
      end
      if (pop_s) begin
        tx_word_count_r <= tx_word_count_r + 32'd1;
      end else begin
        tx_word_count_r <= tx_word_count_r;
      end
    end
  end

  assign tx_pkt_count  = tx_pkt_count_r;
  assign tx_word_count = tx_word_count_r;
`endif

endmodule

// File: doc/pkt_tx_ctrl.md
PKT_TX_CTRL -- requirements
Module: pkt_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the payload bits per word.
REQ-002 SHALL have parameter CTRL_WIDTH, default 8, meaning the control bits per word.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning the pending-packet counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pkt_done, input, 1 bit: a one-cycle pulse meaning one complete non-dropped packet has been committed to the FIFO.
REQ-007 SHALL have port fiforead, output, 1 bit: FIFO read request.
REQ-008 SHALL have port valid_data, input, 1 bit: the FIFO word on in_fifo is valid; it arrives one cycle after fiforead.
REQ-009 SHALL have port in_fifo, input, CTRL_WIDTH+DATA_WIDTH bits: the FIFO word, with ctrl in [71:64] and data in [63:0].
REQ-010 SHALL have ports out_data (output, DATA_WIDTH), out_ctrl (output, CTRL_WIDTH) and out_wr (output, 1): the egress word and its write strobe.
REQ-011 SHALL have port out_rdy, input, 1 bit: the downstream can accept a word this cycle.
REQ-012 SHALL have port pkt_avail, output, CNT_WIDTH bits: committed packets whose EOP word has not yet been fetched.
REQ-013 SHALL have port tx_busy, output, 1 bit: high when the state is not IDLE or the skid buffer is non-empty.

Function
REQ-014 SHALL update pkt_avail as follows:
- +1 on pkt_done;
- -1 when valid_data returns an EOP word;
- unchanged when both occur in the same cycle;
- saturate at the maximum value and at 0, never wrapping.
REQ-015 SHALL hold a 2-entry skid buffer and assert fiforead only when pkt_avail != 0 and (occupancy + reads in flight) < 2.
REQ-016 SHALL write every valid_data word into the skid buffer; the occupancy rule in REQ-015 guarantees the buffer never overflows.
REQ-017 SHALL assert out_wr when the buffer is non-empty and out_rdy=1; out_data and out_ctrl carry the buffer head, which then pops.
REQ-018 SHALL reach the first out_wr 3 cycles after pkt_done when idle with out_rdy=1, and then sustain 1 word per cycle.
REQ-019 SHALL track the egress state machine on popped words:
- IDLE -> HDR on ctrl==0xFF;
- IDLE -> PAYLOAD on ctrl==0x00;
- HDR -> PAYLOAD on ctrl==0x00;
- PAYLOAD -> IDLE on ctrl!=0x00 (EOP).
REQ-020 SHALL classify incoming words with the same decode: EOP = ctrl neither 0x00 nor 0xFF, with the previous word not an EOP.
REQ-021 SHALL accept at most one speculative read past an EOP boundary; if that read returns valid_data=0, no word is queued.
REQ-022 SHALL apply back-pressure so that when out_rdy=0, out_wr=0, out_data and out_ctrl hold, the buffer keeps its contents and fiforead stops once the buffer is full.
REQ-023 SHALL keep out_data and out_ctrl registered; out_wr SHALL never be asserted from an empty buffer.

Reset
REQ-024 SHALL, while rst=0, asynchronously force the following, regardless of the current state or any packet in progress:
- fiforead=0, out_wr=0;
- out_data=0, out_ctrl=0;
- pkt_avail=0, tx_busy=0;
- skid buffer empty, state IDLE.
REQ-025 SHALL, after rst releases, ignore valid_data for reads issued before reset; the FIFO is reset with the same reset.

Configuration
REQ-026 SHALL, with TX_PKT_STATS_EN defined, add 32-bit outputs tx_pkt_count (+1 per transmitted EOP word) and tx_word_count (+1 per out_wr); both reset to 0 and wrap modulo 2^32.
REQ-027 SHALL, without TX_PKT_STATS_EN, have neither those ports nor their logic, with all other behaviour identical.

Verification
REQ-028 SHALL check single packet: 1 hdr(0xFF) + 3 data words with ctrl 00,00,0x04 committed, pkt_done pulse, out_rdy=1 -> out_wr on 4 consecutive cycles starting 3 cycles after pkt_done; pkt_avail 1->0; state returns to IDLE.
REQ-029 SHALL check back-pressure: out_rdy=0 for 5 cycles mid-packet -> out_wr=0; out_data stable; at most 2 words buffered; no loss or duplication after out_rdy=1.
REQ-030 SHALL check a simultaneous event: pkt_done coincident with an EOP fetch while pkt_avail=1 -> pkt_avail stays 1.
REQ-031 SHALL check back-to-back traffic: 3 packets committed, out_rdy=1 -> words emitted contiguously; EOP ctrl 0x01 of packet N is immediately followed by 0xFF of packet N+1.
REQ-032 SHALL check reset mid-packet: rst=0 during word 2 of 4 -> outputs 0 immediately (asynchronously); after release no out_wr until a new pkt_done.
REQ-033 SHALL check saturation: 255 pkt_done pulses then 1 more with no reads -> pkt_avail holds 255.
